// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher between the local-store instruction port and decode
// Ports: clk, rst (sync, active-high); fetch_enable, redirect_valid/redirect_pc steer fetching;
// ls_req/ls_inst_addr issue word fetches, ls_stall blocks issue, ls_inst_in returns LS_LATENCY cycles later;
// dec_valid/dec_inst/dec_pc/dec_ready present the FIFO head to decode.
module inst_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int LS_LATENCY = 1,
  parameter int LS_ADDR_BITS = 18,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ls_req,
  output logic [31:0] ls_inst_addr,
  input  logic        ls_stall,
  input  logic [31:0] ls_inst_in,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] PC_MASK = (LS_ADDR_BITS >= 32) ? 32'hFFFF_FFFC :
                                    ((32'h1 << LS_ADDR_BITS) - 32'h1) & 32'hFFFF_FFFC;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [LS_LATENCY-1:0] pipe_v_q, pipe_v_d;
  logic [LS_LATENCY-1:0][31:0] pipe_pc_q, pipe_pc_d;
  logic [DEPTH-1:0][31:0] inst_q, inst_d, pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [31:0] last_inst_q, last_inst_d, last_pc_q, last_pc_d;
  logic [31:0] inflight;
  logic push, pop;
  assign inflight = 32'($countones(pipe_v_q));
  // Credit covers both buffered and in-flight words so a return always finds a free slot.
  assign ls_req = (state_q == RUN) && !ls_stall && !redirect_valid &&
                  (32'(count_q) + inflight < 32'(DEPTH));
  assign ls_inst_addr = fetch_pc_q;
  assign dec_valid = count_q != '0;
  // When empty, decode sees the last popped word rather than stale storage.
  assign dec_inst = dec_valid ? inst_q[head_q] : last_inst_q;
  assign dec_pc = dec_valid ? pc_q[head_q] : last_pc_q;
  assign pop = dec_valid & dec_ready;
  assign push = pipe_v_q[LS_LATENCY-1] & !redirect_valid;
  always_comb begin
    state_d = state_q == IDLE ? (fetch_enable ? RUN : IDLE) :
              state_q == RUN  ? (fetch_enable ? RUN : DRAIN) :
              fetch_enable ? RUN : (inflight == 0 ? IDLE : DRAIN);
    fetch_pc_d = redirect_valid ? redirect_pc & PC_MASK :
                 ls_req ? (fetch_pc_q + 32'd4) & PC_MASK : fetch_pc_q;
    pipe_v_d = pipe_v_q;
    pipe_pc_d = pipe_pc_q;
    pipe_v_d[0] = ls_req;
    pipe_pc_d[0] = fetch_pc_q;
    for (int i = 1; i < LS_LATENCY; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_pc_d[i] = pipe_pc_q[i-1];
    end
    if (redirect_valid) pipe_v_d = '0;
    inst_d = inst_q;
    pc_d = pc_q;
    if (push) begin
      inst_d[tail_q] = ls_inst_in;
      pc_d[tail_q] = pipe_pc_q[LS_LATENCY-1];
    end
    head_d = redirect_valid ? '0 : pop ? head_q + AW'(1) : head_q;
    tail_d = redirect_valid ? '0 : push ? tail_q + AW'(1) : tail_q;
    count_d = redirect_valid ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    last_inst_d = pop ? inst_q[head_q] : last_inst_q;
    last_pc_d = pop ? pc_q[head_q] : last_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC & PC_MASK;
      pipe_v_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      last_inst_q <= '0;
      last_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pipe_v_q <= pipe_v_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      last_inst_q <= last_inst_d;
      last_pc_q <= last_pc_d;
    end
  end
  always_ff @(posedge clk) begin
    pipe_pc_q <= pipe_pc_d;
    inst_q <= inst_d;
    pc_q <= pc_d;
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed and random stimulus against a transaction-level prefetch model
module tb_inst_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int L = 1;
  localparam logic [31:0] M = 32'h0003_FFFC;
  logic clk = 0;
  logic rst, fetch_enable, redirect_valid, ls_stall, dec_ready, ls_req, dec_valid;
  logic [31:0] redirect_pc, ls_inst_addr, ls_inst_in, dec_inst, dec_pc;
  int checks = 0, errors = 0;
  logic [31:0] q_pc[$];
  int q_t[$];
  logic [31:0] mpc, last_pc, last_inst, prev_addr;
  bit run, prev_req;
  int cyc;
  always #5 clk = ~clk;
  inst_prefetch_queue #(.DEPTH(DEPTH), .LS_LATENCY(L), .LS_ADDR_BITS(18), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_enable(fetch_enable), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ls_req(ls_req), .ls_inst_addr(ls_inst_addr), .ls_stall(ls_stall),
    .ls_inst_in(ls_inst_in), .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_ready(dec_ready)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic fe, input logic rdy, input logic st,
                      input logic rv, input logic [31:0] rp);
    logic er, ev;
    logic [31:0] hp;
    @(negedge clk);
    rst = r; fetch_enable = fe; dec_ready = rdy; ls_stall = st; redirect_valid = rv; redirect_pc = rp;
    ls_inst_in = prev_req ? word(prev_addr) : $urandom;
    #1;
    er = run && !st && !rv && q_pc.size() < DEPTH;
    ev = q_pc.size() > 0 && cyc - q_t[0] > L;
    hp = ev ? q_pc[0] : last_pc;
    if (!r) begin
      chk("ls_req", 32'(ls_req), 32'(er));
      chk("ls_inst_addr", ls_inst_addr, mpc);
      chk("dec_valid", 32'(dec_valid), 32'(ev));
      chk("dec_pc", dec_pc, hp);
      chk("dec_inst", dec_inst, ev ? word(hp) : last_inst);
    end
    prev_req = ls_req;
    prev_addr = ls_inst_addr;
    if (r) begin
      q_pc.delete(); q_t.delete();
      mpc = 0; last_pc = 0; last_inst = 0; run = 0;
    end else begin
      if (ev && rdy) begin
        last_pc = hp; last_inst = word(hp);
        void'(q_pc.pop_front()); void'(q_t.pop_front());
      end
      if (rv) begin
        q_pc.delete(); q_t.delete();
        mpc = rp & M;
      end else if (er) begin
        q_pc.push_back(mpc); q_t.push_back(cyc);
        mpc = (mpc + 32'd4) & M;
      end
      run = fe;
    end
    cyc++;
  endtask
  initial begin
    prev_req = 0; run = 0; cyc = 0; mpc = 0; last_pc = 0; last_inst = 0; prev_addr = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (12) step(0, 1, 1, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h100);
    repeat (6) step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 1, 1, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 32'h3FFFC);
    repeat (5) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 32'h103);
    repeat (5) step(0, 1, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 32'h200);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 1, 0, 0, 0);
    repeat (3000)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
